mdu_seq: RTL and testbench
==========================

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port in_valid  input  1  operation request present.
REQ-004 SHALL have port in_ready  output  1  block can accept a request.
REQ-005 SHALL have port op  input  3  RV32M funct3 (inst[14:12]): 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port src1  input  32  multiplicand/dividend.
REQ-007 SHALL have port src2  input  32  multiplier/divisor.
REQ-008 SHALL have port flush  input  1  abort any in-flight operation.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  32  operation result.
REQ-012 SHALL have port busy  output  1  state != IDLE.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 SHALL accept on the edge where in_valid & in_ready & !flush; it latches op, src1, src2.
REQ-015 SHALL treat op 001/010/011 as MUL (low 32 bits of product).
REQ-016 SHALL, on accept of a normal op, enter CALC with iteration counter 0; perform one iteration per edge; after 32nd iteration enter DONE, so out_valid rises 32 cycles after accept.
REQ-017 SHALL compute MUL by shift-add, returning product[31:0] (identical for signed/unsigned).
REQ-018 SHALL compute DIV/REM by restoring division on magnitudes with sign fixup: quotient negative iff operand signs differ; remainder takes dividend sign.
REQ-019 SHALL, for divisor 0, go IDLE->DONE directly at accept (1-cycle latency): DIV/DIVU result 0xFFFFFFFF, REM/REMU result src1.
REQ-020 SHALL, for DIV/REM with src1=0x80000000 and src2=0xFFFFFFFF, go directly to DONE: DIV 0x80000000, REM 0x00000000.
REQ-021 SHALL hold result and out_valid stable in DONE while out_ready=0.
REQ-022 SHALL leave DONE for IDLE on the edge with out_ready=1; no new accept in that same cycle.
REQ-023 SHALL, on flush=1 in any state, go to IDLE next edge, discard result, clear counter; flush beats in_valid and out_ready in the same cycle.
REQ-024 SHALL ignore in_valid outside IDLE and keep latched operands unchanged until next accept.

Reset
REQ-025 SHALL on rst_n=0 immediately force state IDLE, counter 0, result 0x00000000, out_valid 0, in_ready 1 after release, busy 0.
REQ-026 SHALL abort any operation caught by reset mid-CALC or DONE with no result delivered.

Configuration
REQ-027 SHALL honour macro MDU_FAST_MUL_EN: defined -> MUL ops go IDLE->DONE at accept with single-cycle combinational product (1-cycle latency); undefined -> MUL iterative per REQ-016/017 (32-cycle latency); division unaffected either way.

Verification
REQ-028 SHALL check MUL src1=7, src2=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid 32 cycles after accept (1 cycle with MDU_FAST_MUL_EN).
REQ-029 SHALL check DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each 32-cycle latency.
REQ-030 SHALL check DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, and DIV 0x80000000/-1 -> 0x80000000, all 1-cycle latency.
REQ-031 SHALL check out_ready held 0 for 10 cycles in DONE -> result/out_valid stable, in_ready 0, then one-cycle out_ready -> IDLE.
REQ-032 SHALL check flush at CALC iteration 10 with in_valid=1 -> IDLE next edge, no out_valid, no accept that cycle; next request completes correctly.
REQ-033 SHALL check rst_n pulsed low mid-CALC -> outputs at reset values asynchronously, no stale result after release.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: sequential RV32M multiply/divide unit (shift-add MUL, restoring DIV/REM)
// Ports: clk, rst_n (async active-low); in_valid/in_ready + op/src1/src2 request;
//        out_valid/out_ready + result response; flush aborts; busy = not idle.
// Option: define MDU_FAST_MUL_EN for a single-cycle combinational MUL.
module mdu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [4:0] cnt;
  logic [31:0] acc, a, b;
  logic is_div, is_rem, neg_q, neg_r;
  logic accept, sgn, n1, n2, dz, ovf, fast, short_op, last, ge;
  logic [31:0] mag1, mag2, prod, short_res, acc_n, a_n, b_n, diff, fin;
  logic [32:0] t;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign accept    = in_valid & in_ready & ~flush;
  assign sgn  = op[2] & ~op[0];
  assign n1   = sgn & src1[31];
  assign n2   = sgn & src2[31];
  assign mag1 = n1 ? -src1 : src1;
  assign mag2 = n2 ? -src2 : src2;
  assign dz   = op[2] & (src2 == 32'd0);
  assign ovf  = sgn & (src1 == 32'h8000_0000) & (src2 == 32'hffff_ffff);
`ifdef MDU_FAST_MUL_EN
  assign fast = ~op[2];
  assign prod = src1 * src2;
`else
  assign fast = 1'b0;
  assign prod = 32'd0;
`endif
  assign short_op  = dz | ovf | fast;
  assign short_res = fast ? prod : dz ? (op[1] ? src1 : 32'hffff_ffff) : (op[1] ? 32'd0 : 32'h8000_0000);
  // division step: acc is the partial remainder, a shifts the dividend out and the quotient in
  assign t    = {acc, a[31]};
  assign ge   = t >= {1'b0, b};
  assign diff = t[31:0] - b;
  assign acc_n = is_div ? (ge ? diff : t[31:0]) : acc + (b[0] ? a : 32'd0);
  assign a_n   = is_div ? {a[30:0], ge} : a << 1;
  assign b_n   = is_div ? b : b >> 1;
  assign fin   = !is_div ? acc_n : is_rem ? (neg_r ? -acc_n : acc_n) : (neg_q ? -a_n : a_n);
  assign last  = cnt == 5'd31;
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (state == IDLE) state_n = accept ? (short_op ? DONE : CALC) : IDLE;
    else if (state == CALC) state_n = last ? DONE : CALC;
    else if (state == DONE) state_n = out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= 5'd0;
      acc    <= 32'd0;
      a      <= 32'd0;
      b      <= 32'd0;
      is_div <= 1'b0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= 32'd0;
    end else if (flush) begin
      cnt    <= 5'd0;
      result <= 32'd0;
    end else if (accept) begin
      cnt    <= 5'd0;
      acc    <= 32'd0;
      a      <= op[2] ? mag1 : src1;
      b      <= op[2] ? mag2 : src2;
      is_div <= op[2];
      is_rem <= op[1];
      neg_q  <= n1 ^ n2;
      neg_r  <= n1;
      if (short_op) result <= short_res;
    end else if (state == CALC) begin
      cnt <= cnt + 5'd1;
      acc <= acc_n;
      a   <= a_n;
      b   <= b_n;
      if (last) result <= fin;
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq
module tb_mdu_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [2:0] op = 0;
  logic [31:0] src1 = 0, src2 = 0;
  logic in_ready, out_valid, busy;
  logic [31:0] result;
  int n_chk = 0, n_fail = 0, lat, seen;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  mdu_seq dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
               .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid),
               .out_ready(out_ready), .result(result), .busy(busy));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // lat = rising edges after the accept edge until out_valid is seen
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    in_valid = 1; op = o; src1 = x; src2 = y;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic take();
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    issue(o, x, y);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_lat"}, lat, exp_lat);
    take();
  endtask
  initial begin
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    rst_n = 1;
    run("mul", 3'b000, 32'd7, 32'hffff_fffd, 32'hffff_ffeb, MUL_LAT);
    run("mul_alias", 3'b011, 32'd6, 32'd9, 32'd54, MUL_LAT);
    run("div", 3'b100, -32'sd7, 32'd2, 32'hffff_fffd, 32);
    run("rem", 3'b110, -32'sd7, 32'd2, 32'hffff_ffff, 32);
    run("divu", 3'b101, 32'd100, 32'd7, 32'd14, 32);
    run("remu", 3'b111, 32'd100, 32'd7, 32'd2, 32);
    run("divu_big", 3'b101, 32'hffff_fffe, 32'hffff_ffff, 32'd0, 32);
    run("divu_z", 3'b101, 32'd5, 32'd0, 32'hffff_ffff, 0);
    run("rem_z", 3'b110, 32'd5, 32'd0, 32'd5, 0);
    run("div_ovf", 3'b100, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 0);
    run("rem_ovf", 3'b110, 32'h8000_0000, 32'hffff_ffff, 32'd0, 0);
    // held response: stays stable and new requests are ignored
    issue(3'b101, 32'd100, 32'd7);
    @(negedge clk); in_valid = 1; op = 3'b000; src1 = 32'd3; src2 = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_res", result, 32'd14);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
    end
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    chk("rel_valid", out_valid, 0);
    chk("rel_ready", in_ready, 1);
    chk("rel_no_accept", busy, 0);
    in_valid = 0;
    // flush at iteration 10 with a competing request
    @(negedge clk); in_valid = 1; op = 3'b101; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk); #1; in_valid = 0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1; in_valid = 1; op = 3'b000; src1 = 32'd2; src2 = 32'd2;
    @(posedge clk); #1; flush = 0; in_valid = 0;
    chk("flush_ready", in_ready, 1);
    chk("flush_busy", busy, 0);
    chk("flush_valid", out_valid, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush_no_out", seen, 0);
    run("post_flush", 3'b111, 32'd100, 32'd7, 32'd2, 32);
    // asynchronous reset mid-calculation
    @(negedge clk); in_valid = 1; op = 3'b100; src1 = 32'd50; src2 = 32'd5;
    @(posedge clk); #1; in_valid = 0;
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_result", result, 0);
    @(negedge clk); rst_n = 1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || result != 0) seen++;
    end
    chk("arst_no_stale", seen, 0);
    run("post_rst", 3'b100, 32'd50, -32'sd5, 32'hffff_fff6, 32);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
